// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: one-hot HGRANT with HMASTER/HMASTLOCK address-phase tracking for up to 8 masters.
// Latency: grant one HCLK after a qualifying request; HMASTER follows at the next HREADY edge. Backpressure: HREADY=0 freezes all state.
// Policy: fixed priority (lowest index) by default; round-robin when AHB_ARB_ROUND_ROBIN_EN is defined.
module ahb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MASTER_W    = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MASTER_W-1:0]    HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    logic [4:0]          beats_left;
    logic [4:0]          beats_nxt;
    logic [MASTER_W-1:0] g;
    logic [MASTER_W-1:0] sel;
    logic                locked;
    logic                arb_ok;

    always_comb begin
        g = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (HGRANT[i]) g = MASTER_W'(i);
        end
    end

    always_comb begin
        beats_nxt = beats_left;
        if (!HREADY) begin
            if (HRESP != RESP_OKAY) beats_nxt = '0;
        end else if (HTRANS == TR_NONSEQ) begin
            case (HBURST)
                3'b010, 3'b011: beats_nxt = 5'd3;
                3'b100, 3'b101: beats_nxt = 5'd7;
                3'b110, 3'b111: beats_nxt = 5'd15;
                default:        beats_nxt = 5'd0;
            endcase
        end else if (HTRANS == TR_SEQ && beats_left != 5'd0) begin
            beats_nxt = beats_left - 5'd1;
        end
    end

    // Burst end is judged on the count this edge leaves behind, so the
    // handover lands on the edge that accepts the final beat.
    assign locked = HLOCK[g] & HBUSREQ[g];
    assign arb_ok = HREADY && !locked &&
                    ((HTRANS == TR_IDLE) ||
                     (beats_nxt == 5'd0 && HTRANS != TR_BUSY) ||
                     (!HBUSREQ[g] && HTRANS != TR_SEQ));

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [MASTER_W-1:0] ptr;

    always_comb begin
        logic                found;
        logic [MASTER_W-1:0] idx;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = MASTER_W'((int'(ptr) + k) % NUM_MASTERS);
            if (!found && HBUSREQ[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (HBUSREQ[i]) sel = MASTER_W'(i);
        end
    end
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HGRANT     <= NUM_MASTERS'(1);
            HMASTER    <= '0;
            HMASTLOCK  <= 1'b0;
            beats_left <= '0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
            ptr        <= '0;
`endif
        end else begin
            beats_left <= beats_nxt;
            if (arb_ok && sel != g) begin
                HGRANT <= NUM_MASTERS'(1) << sel;
`ifdef AHB_ARB_ROUND_ROBIN_EN
                ptr    <= sel;
`endif
            end
            // Address phase belongs to whoever held the grant when it was accepted.
            if (HREADY) begin
                HMASTER   <= g;
                HMASTLOCK <= HLOCK[g];
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;
    localparam logic [2:0] INCR16 = 3'b111;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] RETRY  = 2'b10;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [1:0] HRESP;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_arbiter #(.NUM_MASTERS(4), .MASTER_W(2)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of bus inputs, clock it in, and settle just after the edge.
    task automatic cyc(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic rdy, input logic [1:0] resp);
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = trans;
        HBURST  = burst;
        HREADY  = rdy;
        HRESP   = resp;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_gnt;
        logic [1:0] exp_mst;

        HRESETn = 1'b0;
        HBUSREQ = '0;
        HLOCK   = '0;
        HTRANS  = IDLE;
        HBURST  = SINGLE;
        HREADY  = 1'b1;
        HRESP   = OKAY;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_grant", 32'(HGRANT), 32'h1);
        check("rst_master", 32'(HMASTER), 32'h0);
        check("rst_mastlock", 32'(HMASTLOCK), 32'h0);
        check("rst_beats", 32'(dut.beats_left), 32'h0);
        HRESETn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
            check("idle_grant", 32'(HGRANT), 32'h1);
        end
        check("idle_master", 32'(HMASTER), 32'h0);
        check("idle_mastlock", 32'(HMASTLOCK), 32'h0);

        // INCR4 by master 2, master 1 joins on beat 2
        cyc(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check("a_grant_m2", 32'(HGRANT), 32'h4);
        cyc(4'b0100, 4'b0000, NONSEQ, INCR4, 1'b1, OKAY);
        check("a_beat1_grant", 32'(HGRANT), 32'h4);
        check("a_beat1_master", 32'(HMASTER), 32'h2);
        check("a_beat1_count", 32'(dut.beats_left), 32'h3);
        cyc(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
        check("a_beat2_grant", 32'(HGRANT), 32'h4);
        cyc(4'b0110, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
        check("a_beat3_grant", 32'(HGRANT), 32'h4);
        cyc(4'b0010, 4'b0000, SEQ, INCR4, 1'b1, OKAY);
        check("a_beat4_grant", 32'(HGRANT), 32'h2);
        check("a_beat4_master", 32'(HMASTER), 32'h2);
        cyc(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check("a_handover_master", 32'(HMASTER), 32'h1);
        check("a_handover_grant", 32'(HGRANT), 32'h2);

        // Master 3 locked across two INCR4 bursts while master 0 waits
        cyc(4'b1000, 4'b1000, IDLE, SINGLE, 1'b1, OKAY);
        check("b_grant_m3", 32'(HGRANT), 32'h8);
        for (int i = 0; i < 8; i++) begin
            cyc(4'b1001, 4'b1000, (i % 4 == 0) ? NONSEQ : SEQ, INCR4, 1'b1, OKAY);
            check("b_lock_grant", 32'(HGRANT), 32'h8);
            check("b_lock_mastlock", 32'(HMASTLOCK), 32'h1);
            check("b_lock_master", 32'(HMASTER), 32'h3);
        end
        cyc(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check("b_release_grant", 32'(HGRANT), 32'h1);
        cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check("b_release_master", 32'(HMASTER), 32'h0);
        check("b_release_mastlock", 32'(HMASTLOCK), 32'h0);

        // INCR8 by master 2 with three wait states on beat 2, master 3 pending
        cyc(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check("c_grant_m2", 32'(HGRANT), 32'h4);
        cyc(4'b1100, 4'b0000, NONSEQ, INCR8, 1'b1, OKAY);
        check("c_beat1_count", 32'(dut.beats_left), 32'h7);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1100, 4'b0000, SEQ, INCR8, 1'b0, OKAY);
            check("c_wait_grant", 32'(HGRANT), 32'h4);
            check("c_wait_master", 32'(HMASTER), 32'h2);
            check("c_wait_count", 32'(dut.beats_left), 32'h7);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(4'b1100, 4'b0000, SEQ, INCR8, 1'b1, OKAY);
            check("c_mid_grant", 32'(HGRANT), 32'h4);
            check("c_mid_count", 32'(dut.beats_left), 32'(6 - i));
        end
        cyc(4'b1000, 4'b0000, SEQ, INCR8, 1'b1, OKAY);
        check("c_beat8_grant", 32'(HGRANT), 32'h8);
        check("c_beat8_count", 32'(dut.beats_left), 32'h0);
        cyc(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check("c_handover_master", 32'(HMASTER), 32'h3);

        // RETRY aborts an INCR16 by master 2 while master 1 waits
        cyc(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        check("d_grant_m2", 32'(HGRANT), 32'h4);
        cyc(4'b0110, 4'b0000, NONSEQ, INCR16, 1'b1, OKAY);
        check("d_beat1_count", 32'(dut.beats_left), 32'hf);
        cyc(4'b0110, 4'b0000, SEQ, INCR16, 1'b1, OKAY);
        cyc(4'b0110, 4'b0000, SEQ, INCR16, 1'b1, OKAY);
        check("d_beat3_count", 32'(dut.beats_left), 32'hd);
        check("d_beat3_grant", 32'(HGRANT), 32'h4);
        cyc(4'b0110, 4'b0000, SEQ, INCR16, 1'b0, RETRY);
        check("d_retry_count", 32'(dut.beats_left), 32'h0);
        check("d_retry_grant", 32'(HGRANT), 32'h4);
        cyc(4'b0110, 4'b0000, IDLE, INCR16, 1'b1, RETRY);
        check("d_retry_handover", 32'(HGRANT), 32'h2);

        // Asynchronous reset in the middle of a burst
        cyc(4'b0010, 4'b0000, NONSEQ, INCR4, 1'b1, OKAY);
        check("e_pre_count", 32'(dut.beats_left), 32'h3);
        check("e_pre_master", 32'(HMASTER), 32'h1);
        #3;
        HRESETn = 1'b0;
        #1;
        check("e_arst_grant", 32'(HGRANT), 32'h1);
        check("e_arst_master", 32'(HMASTER), 32'h0);
        check("e_arst_count", 32'(dut.beats_left), 32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // All four masters request continuously with SINGLE transfers
        for (int k = 1; k <= 8; k++) begin
            cyc(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY);
`ifdef AHB_ARB_ROUND_ROBIN_EN
            exp_gnt = 4'b0001 << (k % 4);
            exp_mst = 2'((k - 1) % 4);
`else
            exp_gnt = 4'b0001;
            exp_mst = 2'd0;
`endif
            check("f_single_grant", 32'(HGRANT), 32'(exp_gnt));
            check("f_single_master", 32'(HMASTER), 32'(exp_mst));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

- Central AHB bus arbiter for up to 8 `ahb_master` instances.
- Samples each master's `HBUSREQ` and `HLOCK` and drives one-hot `HGRANT` back to the masters.
- Tracks address-phase ownership (`HMASTER`, `HMASTLOCK`) for the address/control mux and slaves.
- Grants hand over only at legal AHB arbitration points: idle bus, final beat of a fixed-length burst, or an aborted transfer.

## Interface
- NUM_MASTERS, 4, number of requesting masters (2..8)
- MASTER_W, 2, width of HMASTER; must be ≥ clog2(NUM_MASTERS)
- HCLK  in  1  bus clock, all state on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HBUSREQ  in  NUM_MASTERS  per-master bus request
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request
- HTRANS  in  2  muxed transfer type of current owner: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HBURST  in  3  muxed burst type: 000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16
- HREADY  in  1  bus ready from slave mux
- HRESP  in  2  slave response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
- HGRANT  out  NUM_MASTERS  one-hot grant, registered
- HMASTER  out  MASTER_W  index of master owning the address phase, registered
- HMASTLOCK  out  1  current address phase is locked, registered

## Operation
- Reset values:
  - HGRANT = 1 (master 0, the default master).
  - HMASTER = 0, HMASTLOCK = 0.
  - Beat counter `beats_left` = 0.
  - Round-robin pointer = 0.
- Owner: index `g` of the set bit in HGRANT. Exactly one bit is set at all times.
- Beat counter (5 bits):
  - On HREADY=1 and HTRANS=NONSEQ: load 4/8/16 minus 1 for 4-, 8- and 16-beat bursts; load 0 for SINGLE and INCR.
  - On HREADY=1 and HTRANS=SEQ: decrement if nonzero.
  - Hold on BUSY, IDLE or HREADY=0.
  - HRESP ∈ {ERROR, RETRY, SPLIT} with HREADY=0 clears it to 0 (burst aborted).
- Arbitration point `arb_ok` = HREADY=1 and not `locked` and one of:
  - HTRANS=IDLE;
  - `beats_left`=0 and HTRANS≠BUSY;
  - HBUSREQ[g]=0 and HTRANS≠SEQ.
- `locked` = HLOCK[g] & HBUSREQ[g]. While set, the grant never moves, including at burst end.
- Selection when `arb_ok`:
  - Choose among masters with HBUSREQ=1 per the configured policy.
  - If none request, grant master 0.
  - If the selected master equals `g`, HGRANT is unchanged.
- Address-phase tracking: on every HREADY=1 edge, HMASTER ← g and HMASTLOCK ← HLOCK[g]. Both hold while HREADY=0.
- Simultaneous events: a new request arriving in the same cycle as `arb_ok` is included in that cycle's selection.
- An asynchronous reset mid-burst returns to the reset values immediately and discards the burst.

## Timing
- Grant latency: a request sampled at edge N with `arb_ok` true at N gives HGRANT at N+1.
- HMASTER follows HGRANT at the first HREADY=1 edge after the grant changes (one-cycle handover pipeline).
- A fixed-length burst of L beats with HREADY constantly 1 holds the grant for L address cycles. The grant may move at the edge accepting the last beat.
- Wait states (HREADY=0) freeze HGRANT, HMASTER, HMASTLOCK and `beats_left`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- AHB_ARB_ROUND_ROBIN_EN
  - Defined: round-robin selection. The search starts at index `ptr`+1 modulo NUM_MASTERS. `ptr` ← newly granted index on each grant change.
  - Undefined: fixed priority, lowest index wins. `ptr` logic is not synthesised.
  - All other behaviour is identical in both builds.

## Test plan
- Reset with HBUSREQ=0: HGRANT=0001, HMASTER=0, HMASTLOCK=0.
  - Idle bus (HTRANS=IDLE, HREADY=1) for 10 cycles: values unchanged.
- Master 2 requests and issues an INCR4 (NONSEQ, then 3 SEQ, HREADY=1) while master 1 requests from the second beat:
  - HGRANT=0100 for all 4 beats.
  - HGRANT=0010 after the edge accepting beat 4.
  - HMASTER=1 one HREADY edge later.
- Master 3 holds HLOCK=1 and HBUSREQ=1 across two INCR4 bursts while master 0 requests: HGRANT stays 1000 and HMASTLOCK=1 throughout both bursts.
- Insert 3 wait states on beat 2 of an INCR8: HGRANT, HMASTER and the beat count are frozen.
  - Burst still completes 8 beats before the grant moves.
- HRESP=RETRY with HREADY=0 mid-INCR16 while master 1 is pending: `beats_left` clears and HGRANT moves to master 1 on the next HREADY=1 edge.
- All four masters request continuously with SINGLE transfers:
  - With AHB_ARB_ROUND_ROBIN_EN: grants cycle 0→1→2→3→0.
  - Without it: master 0 holds the grant every cycle.
